// File: rtl/serial_responder_pkg.sv
// Shared types and constants for the latch/pulse serial responder.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } resp_state_t;

    // Level driven on the line outside a frame and shifted in behind the data.
    localparam logic FILL_BIT = 1'b1;

endpackage

// File: rtl/serial_responder_sync_edge.sv
// Input conditioning for one host control line: an optional 2-flop
// synchronizer (enabled by macro SERIAL_RESP_SYNC_EN), then a
// previous-value register that produces the rising-edge strobe.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic level_o,
    output logic rise_o
);

    logic prev_q;

`ifdef SERIAL_RESP_SYNC_EN
    logic meta_q;
    logic sync_q;

    // Two-stage synchronizer for inputs from pins or a foreign clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
        end
    end

    assign level_o = sync_q;
`else
    assign level_o = in_i;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_o;
        end
    end

    assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/serial_responder.sv
// Device-side latch/pulse shift-register responder. Loads data_in while the
// host latch is high, then shifts it out MSB-first, one bit per pulse.
// Optional input synchronizers: define SERIAL_RESP_SYNC_EN.
module serial_responder
    import serial_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            latch,
    input  logic            pulse,
    input  logic [BITS-1:0] data_in,
    output logic            data_out,
    output logic            busy,
    output logic            frame_done,
    output logic            extra_pulse
);

    localparam int unsigned CW = $clog2(BITS + 1);

    logic latch_s;
    logic latch_rise;
    logic pulse_s;
    logic pulse_rise;

    resp_state_t     state_q, state_d;
    logic [BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            fd_q, fd_d;
    logic            xp_q, xp_d;

    sync_edge u_latch_edge (
        .clk     (clk),
        .reset   (reset),
        .in_i    (latch),
        .level_o (latch_s),
        .rise_o  (latch_rise)
    );

    sync_edge u_pulse_edge (
        .clk     (clk),
        .reset   (reset),
        .in_i    (pulse),
        .level_o (pulse_s),
        .rise_o  (pulse_rise)
    );

    // Next-state logic: latch overrides everything, otherwise per-state handling.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        xp_d    = xp_q;

        if (latch_s) begin
            // Transparent load; any pulse edge in this cycle is discarded.
            state_d = LOAD;
            sr_d    = data_in;
            cnt_d   = '0;
            // LOAD is only entered on a latch rising edge, so clearing here
            // is the same as clearing on entry.
            if (latch_rise) begin
                xp_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (pulse_rise) begin
                        xp_d = 1'b1;
                    end
                end
                LOAD: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        sr_d  = {sr_q[BITS-2:0], FILL_BIT};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CW'(BITS)) begin
                            state_d = DONE;
                            fd_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Output is taken from the pending register value only once already in
        // LOAD/SHIFT, which gives the two-cycle latch-to-first-bit timing.
        if (state_q == LOAD || state_q == SHIFT) begin
            dout_d = sr_d[BITS-1];
        end else begin
            dout_d = FILL_BIT;
        end

        busy_d = (state_d == LOAD) || (state_d == SHIFT);
    end

    // State, shift register, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            dout_q  <= FILL_BIT;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            xp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
            xp_q    <= xp_d;
        end
    end

    assign data_out    = dout_q;
    assign busy        = busy_q;
    assign frame_done  = fd_q;
    assign extra_pulse = xp_q;

endmodule

// File: doc/serial_responder.md
# serial_responder

Device-side end of the latch/pulse serial link used by the joystick path: holds a parallel word, loads it on the host's latch, and shifts it out MSB-first, one bit per pulse, on a single serial line. It sits wherever the FPGA must appear as a shift-register controller to a latch/pulse host, such as an FPGA-to-FPGA link or a bench loopback against the joystick host driver. It adds frame status so the owning logic knows when a word has been consumed.

## Interface
- BITS, default 16: frame length in bits; legal range 2..64.
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- latch  input  1  host latch; a high level loads the word.
- pulse  input  1  host shift clock; each rising edge advances one bit.
- data_in  input  BITS  parallel word to send; bit BITS-1 is sent first.
- data_out  output  1  serial bit to the host.
- busy  output  1  high in LOAD or SHIFT.
- frame_done  output  1  one-cycle strobe when the last bit has been shifted past.
- extra_pulse  output  1  sticky flag: a pulse arrived in DONE or IDLE; cleared by the next latch.

## Operation
- Edge detection: latch_s and pulse_s are the conditioned inputs (see Configuration). Each is registered once.
  - pulse_rise = pulse_s & ~pulse_q.
- States: IDLE, LOAD, SHIFT, DONE. The state type lives in the package.
- IDLE: data_out = FILL_BIT (1).
  - latch_s high -> LOAD.
  - pulse_rise -> set extra_pulse.
- LOAD: shift register <= data_in on every cycle while latch_s is high (transparent parallel load). bit_count <= 0. pulse_rise is ignored.
  - latch_s low -> SHIFT.
- SHIFT: data_out = shift register MSB.
  - pulse_rise: shift left, inserting FILL_BIT at the LSB; bit_count++.
  - When bit_count reaches BITS -> DONE, and frame_done pulses in the same cycle as the state update.
- DONE: data_out = FILL_BIT.
  - pulse_rise -> set extra_pulse.
- Latch priority: from any state, latch_s high -> LOAD. This includes a mid-frame re-latch (partial frame abandoned, no frame_done) and a latch coinciding with pulse_rise (latch wins, pulse discarded).
- extra_pulse is cleared on entry to LOAD.
- Arithmetic: bit_count is $clog2(BITS+1) bits wide, unsigned, and never exceeds BITS.
- Reset values: state IDLE, data_out 1, busy 0, frame_done 0, extra_pulse 0, bit_count 0, shift register all ones.

## Timing
- data_out, busy and frame_done are registered outputs, with no combinational path from the inputs.
- Latency from the input edge to the output change, with SERIAL_RESP_SYNC_EN undefined:
  - latch rise -> state LOAD and busy high: 1 cycle.
  - latch rise -> data_out shows data_in[BITS-1]: 2 cycles.
  - pulse rise -> next bit on data_out: 1 cycle.
- With SERIAL_RESP_SYNC_EN defined, every latency above grows by 2 cycles.
- The host must hold latch high for at least 1 cycle, plus 2 with sync.
- The host must hold pulse high and low for at least 1 cycle each, plus 2 each with sync.
- The host samples bit N before it issues pulse N+1, so bit 0 (the MSB) is valid between latch falling and the first pulse.
- data_in is sampled on the final LOAD cycle. Changes to data_in after that have no effect on the frame.
- frame_done is asserted for exactly 1 cycle.

## Configuration
- Macro SERIAL_RESP_SYNC_EN.
- Defined: latch and pulse each pass through a 2-flop synchronizer before edge detection. Required when the inputs come from pins or another clock domain.
- Undefined: latch_s = latch and pulse_s = pulse. Use this only when the host shares clk.

## Structure
- Package serial_pkg holds:
  - typedef enum logic [1:0] resp_state_t {IDLE, LOAD, SHIFT, DONE};
  - localparam FILL_BIT = 1'b1.
- One sub-module, sync_edge: an optional 2-flop synchronizer plus a previous-value register, outputting the level and the rise signal. There is one instance each for latch and pulse; the macro is handled inside it.
- The top level holds the FSM, the shift register, bit_count and the flags.

## Test plan
- Reset then idle: assert reset for 3 cycles, toggle pulse 2 times.
  - Required: data_out = 1, busy = 0, extra_pulse = 1.
- Full frame: BITS = 16, data_in = 0xA53C, latch held 2 cycles, then 16 pulses.
  - Required: the host-sampled stream is 1010_0101_0011_1100.
  - Required: frame_done is high for 1 cycle after the 16th pulse, then data_out = 1.
- Overrun: after a full frame, send 3 more pulses.
  - Required: data_out stays 1 and extra_pulse = 1.
  - Then latch again. Required: extra_pulse = 0 and busy = 1.
- Mid-frame re-latch: send 0xFFFF, stop after 5 pulses, set data_in = 0x0001 and latch.
  - Required: no frame_done; a fresh 16-bit frame reads 0x0001.
- Latch/pulse collision: raise pulse and latch in the same cycle during SHIFT.
  - Required: the state goes to LOAD, bit_count = 0, and no shift occurs.
- Sync build: repeat the full-frame test with SERIAL_RESP_SYNC_EN defined and pulses 3 cycles high and 3 low.
  - Required: the same stream, with every latency 2 cycles longer.
